// File: rtl/fifo_rd_packer_pkg.sv
// rtl/fifo_rd_packer_pkg.sv - shared state encoding and keep-mask helper for fifo_rd_packer
package fifo_rd_packer_pkg;

  // Widest packing factor the keep-mask helper has to cover.
  localparam int MAX_PACK = 16;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Low-n-bits-set mask; n == MAX_PACK yields all ones.
  function automatic logic [MAX_PACK-1:0] keep_mask(input int unsigned n);
    logic [MAX_PACK:0] w_m;
    w_m = ((MAX_PACK+1)'(1) << n) - (MAX_PACK+1)'(1);
    return w_m[MAX_PACK-1:0];
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs PACK FIFO entries into one wide word, with flush of partial words
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int PACK  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_rempty,
  input  logic [DSIZE-1:0]       i_rdata,
  output logic                   o_rd,
  input  logic                   i_flush,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [DSIZE*PACK-1:0]  o_data,
  output logic [PACK-1:0]        o_keep,
  output logic                   o_busy
);

  localparam int CW = $clog2(PACK) + 1;
  localparam logic [CW-1:0] PACK_C = CW'(PACK);

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_cap, w_cnt_nxt;
  logic                    r_inflight;
  logic                    r_flush_pend, w_flush_pend_nxt;
  logic [DSIZE*PACK-1:0]   r_acc, w_acc_cap, w_acc_nxt, w_data_masked;
  logic [DSIZE*PACK-1:0]   r_data, w_data_nxt;
  logic [PACK-1:0]         r_keep, w_keep_nxt;
  logic                    r_valid, w_valid_nxt;
  logic                    w_slot_free, w_full_emit, w_drain_done, w_emit, w_rd;

  // The output register can take a new word when empty or being accepted this edge.
  assign w_slot_free = !r_valid || i_ready;

  // Read only while room remains for the entry, filling, and no flush pending; gated by reset.
  assign w_rd = i_rst_n && !i_rempty && ((r_cnt + CW'(r_inflight)) < PACK_C) &&
                (r_state == ST_FILL) && !r_flush_pend;

  // Capture the in-flight entry into lane cnt, then zero lanes not yet filled for output.
  always_comb begin
    w_acc_cap     = r_acc;
    w_cnt_cap     = r_cnt;
    w_data_masked = '0;
    for (int k = 0; k < PACK; k++) begin
      if (r_inflight && (r_cnt[CW-2:0] == (CW-1)'(k))) begin
        w_acc_cap[k*DSIZE +: DSIZE] = i_rdata;
      end
    end
    if (r_inflight) begin
      w_cnt_cap = r_cnt + CW'(1);
    end
    for (int k = 0; k < PACK; k++) begin
      if (CW'(k) < w_cnt_cap) begin
        w_data_masked[k*DSIZE +: DSIZE] = w_acc_cap[k*DSIZE +: DSIZE];
      end
    end
  end

  // Next-state: word emission, output handshake and FILL/DRAIN control.
  always_comb begin
    w_state_nxt      = r_state;
    w_flush_pend_nxt = r_flush_pend;
    w_cnt_nxt        = w_cnt_cap;
    w_acc_nxt        = w_acc_cap;
    w_valid_nxt      = r_valid && !i_ready;
    w_data_nxt       = r_data;
    w_keep_nxt       = r_keep;

    w_full_emit  = (w_cnt_cap == PACK_C) && w_slot_free;
    w_drain_done = (r_state == ST_DRAIN) && !r_inflight && w_slot_free;
    w_emit       = w_full_emit || (w_drain_done && (w_cnt_cap != '0));

    if (w_emit) begin
      w_valid_nxt = 1'b1;
      w_data_nxt  = w_data_masked;
      w_keep_nxt  = PACK'(keep_mask(32'(w_cnt_cap)));
      w_cnt_nxt   = '0;
      w_acc_nxt   = '0;
    end

    case (r_state)
      ST_FILL: begin
        if (i_flush) begin
          w_flush_pend_nxt = 1'b1;
          w_state_nxt      = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_drain_done) begin
          w_flush_pend_nxt = 1'b0;
          w_state_nxt      = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // State, accumulator and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_FILL;
      r_cnt        <= '0;
      r_inflight   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_acc        <= '0;
      r_data       <= '0;
      r_keep       <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_inflight   <= w_rd;
      r_flush_pend <= w_flush_pend_nxt;
      r_acc        <= w_acc_nxt;
      r_data       <= w_data_nxt;
      r_keep       <= w_keep_nxt;
      r_valid      <= w_valid_nxt;
    end
  end

  assign o_rd    = w_rd;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_keep  = r_keep;
  assign o_busy  = (r_cnt != '0) || r_inflight || r_flush_pend;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - self-checking bench for fifo_rd_packer
module tb_fifo_rd_packer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_rempty = 1'b1;
  logic [7:0]  i_rdata = 8'h00;
  logic        o_rd;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  ref_q[$];
  logic [35:0] out_q[$];
  logic        rd_s;
  logic        hold = 1'b0;
  logic [31:0] hold_data;
  logic [3:0]  hold_keep;

  fifo_rd_packer #(.DSIZE(8), .PACK(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rempty(i_rempty), .i_rdata(i_rdata),
    .o_rd(o_rd), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_keep(o_keep), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // FIFO read side: a read seen at the edge returns data just after it; empty is registered-like
  always @(posedge i_clk) begin
    rd_s = o_rd;
    #1;
    if (rd_s && fifo_q.size() > 0) i_rdata = fifo_q.pop_front();
    i_rempty = (fifo_q.size() == 0);
  end

  // Output monitor: protocol checks and collection of accepted words
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      hold = 1'b0;
    end else begin
      checks++;
      assert ((o_rd & i_rempty) === 1'b0) else begin
        errors++;
        $error("FAIL rd_while_empty observed=%0b expected=0", o_rd & i_rempty);
      end
      if (hold) begin
        checks++;
        assert ({o_valid, o_data, o_keep} === {1'b1, hold_data, hold_keep}) else begin
          errors++;
          $error("FAIL hold_stable observed=%0b/%08h/%0h expected=1/%08h/%0h",
                 o_valid, o_data, o_keep, hold_data, hold_keep);
        end
      end
      hold      = o_valid && !i_ready;
      hold_data = o_data;
      hold_keep = o_keep;
      if (o_valid && i_ready) out_q.push_back({o_keep, o_data});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fifo_q.push_back(d);
    i_rempty = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] d, input logic [3:0] k);
    logic [35:0] w;
    int t;
    t = 0;
    while (out_q.size() == 0 && t < 100) begin
      tick(1);
      t++;
    end
    if (out_q.size() == 0) begin
      chk({tag, "_timeout"}, 64'(out_q.size()), 64'd1);
    end else begin
      w = out_q.pop_front();
      chk({tag, "_data"}, 64'(w[31:0]), 64'(d));
      chk({tag, "_keep"}, 64'(w[35:32]), 64'(k));
    end
  endtask

  task automatic pulse_flush();
    i_flush = 1'b1;
    tick(1);
    i_flush = 1'b0;
  endtask

  initial begin
    logic [9:0]  rd_bits;
    int          cnt;
    int          t;
    int          n;
    logic [35:0] w;
    logic [8:0]  exp9;

    // Reset
    tick(3);
    chk("reset_outputs", 64'({o_rd, o_valid, o_data, o_keep, o_busy}), 64'd0);
    i_rst_n = 1'b1;
    tick(2);

    // Steady stream
    i_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    rd_bits = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      rd_bits = {rd_bits[8:0], o_rd};
    end
    chk("steady_rd_pattern", 64'(rd_bits), 64'(10'b1111011110));
    expect_word("steady_w0", 32'h04030201, 4'hF);
    expect_word("steady_w1", 32'h08070605, 4'hF);
    tick(3);
    chk("steady_idle_busy", 64'(o_busy), 64'd0);

    // Backpressure: extra entry must stay in the FIFO while a full word waits
    i_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(8'(8'h10 + i));
    cnt = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge i_clk);
      cnt += int'(o_rd);
    end
    chk("bp_rd_count", 64'(cnt), 64'd8);
    chk("bp_held_data", 64'({o_valid, o_data}), 64'({1'b1, 32'h13121110}));
    chk("bp_busy", 64'(o_busy), 64'd1);
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    expect_word("bp_w0", 32'h13121110, 4'hF);
    expect_word("bp_w1", 32'h17161514, 4'hF);
    tick(4);
    pulse_flush();
    expect_word("bp_leftover", 32'h00000018, 4'b0001);

    // Partial flush
    tick(3);
    push(8'hA1); push(8'hA2); push(8'hA3);
    tick(6);
    chk("partial_busy", 64'({o_busy, o_valid}), 64'(2'b10));
    pulse_flush();
    expect_word("partial", 32'h00A3A2A1, 4'b0111);
    chk("partial_busy_after", 64'(o_busy), 64'd0);

    // Flush with a read in flight
    tick(3);
    push(8'hB1); push(8'hB2); push(8'hB3);
    tick(1);
    chk("inflight_second_rd", 64'(o_rd), 64'd1);
    pulse_flush();
    chk("inflight_rd_stopped", 64'(o_rd), 64'd0);
    expect_word("inflight", 32'h0000B2B1, 4'b0011);
    push(8'hB4); push(8'hB5); push(8'hB6);
    expect_word("inflight_next", 32'hB6B5B4B3, 4'hF);

    // Empty flush and idle empty FIFO
    tick(3);
    pulse_flush();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      cnt += int'(o_valid);
    end
    chk("empty_flush_valid", 64'(cnt), 64'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      cnt += int'(o_rd);
    end
    chk("empty_fifo_rd", 64'(cnt), 64'd0);
    chk("empty_busy", 64'(o_busy), 64'd0);

    // Async reset mid-word
    @(posedge i_clk);
    #1;
    push(8'hE1); push(8'hE2);
    tick(5);
    chk("pre_reset_busy", 64'({o_busy, o_valid}), 64'(2'b10));
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({o_rd, o_valid, o_data, o_keep, o_busy}), 64'd0);
    tick(2);
    i_rst_n = 1'b1;
    tick(2);
    chk("no_word_after_reset", 64'(out_q.size()), 64'd0);
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    expect_word("post_reset", 32'hC4C3C2C1, 4'hF);

    // Randomized traffic: kept lanes of all words must replay the pushed stream in order
    tick(3);
    out_q.delete();
    ref_q.delete();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) begin
        exp9[7:0] = 8'($urandom);
        push(exp9[7:0]);
        ref_q.push_back(exp9[7:0]);
      end
      i_ready = ($urandom_range(0, 3) != 0);
      i_flush = ($urandom_range(0, 24) == 0);
      tick(1);
    end
    i_flush = 1'b0;
    i_ready = 1'b1;
    t = 0;
    while (fifo_q.size() != 0 && t < 200) begin
      tick(1);
      t++;
    end
    tick(4);
    pulse_flush();
    t = 0;
    while ((o_busy || o_valid) && t < 200) begin
      tick(1);
      t++;
    end
    tick(2);
    chk("rand_drained", 64'({o_busy, o_valid}), 64'd0);
    while (out_q.size() > 0) begin
      w = out_q.pop_front();
      n = $countones(w[35:32]);
      chk("rand_keep_shape", 64'(w[35:32]), 64'((1 << n) - 1));
      chk("rand_keep_nonzero", 64'(n != 0), 64'd1);
      for (int j = 0; j < 4; j++) begin
        if (j < n) exp9 = (ref_q.size() > 0) ? {1'b0, ref_q.pop_front()} : 9'h100;
        else       exp9 = 9'h000;
        chk("rand_lane", 64'({1'b0, w[j*8 +: 8]}), 64'(exp9));
      end
    end
    chk("rand_leftover", 64'(ref_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of the asynchronous FIFO, running in the FIFO read clock domain.
- Pops DSIZE-bit entries through the FIFO read port (empty flag, read strobe, read data).
- Packs PACK consecutive entries into one wide word for a downstream valid/ready sink.
- A flush request forces out a partial word with a per-lane keep mask.

Parameters:
- DSIZE, 8, width of one FIFO entry (must match the FIFO).
- PACK, 4, entries per output word; power of two, 2..16.
- CW, $clog2(PACK)+1, lane-count width (localparam).

Ports:
- i_clk  input  1  read-domain clock (same clock as the FIFO read side).
- i_rst_n  input  1  asynchronous active-low reset.
- i_rempty  input  1  FIFO empty flag.
- i_rdata  input  DSIZE  FIFO read data, valid one cycle after o_rd.
- o_rd  output  1  FIFO read strobe.
- i_flush  input  1  single-cycle request to emit the pending partial word.
- o_valid  output  1  output word valid.
- i_ready  input  1  downstream accept.
- o_data  output  DSIZE*PACK  packed word; lane 0 = first entry popped, in bits [DSIZE-1:0].
- o_keep  output  PACK  lane-valid mask; bit k covers lane k.
- o_busy  output  1  high when lanes are accumulated, a read is in flight, or a flush is pending.

Behaviour:
- Reset (async, i_rst_n low): state FILL; cnt=0; inflight=0; flush_pend=0; accumulator cleared.
  - Outputs: o_rd=0, o_valid=0, o_data=0, o_keep=0, o_busy=0.
  - Reset mid-word discards accumulated lanes and any in-flight entry; no partial word is emitted.
- Read issue (combinational): o_rd = !i_rempty && (cnt+inflight < PACK) && state==FILL && !flush_pend.
  - inflight <= o_rd at each edge.
- Capture: when inflight=1, i_rdata is written into lane cnt and cnt increments.
- Word completion: when the captured lane makes cnt==PACK:
  - If the output slot is free (o_valid==0 or i_ready==1), at that same edge: o_data<=accumulator, o_keep<=all ones, o_valid<=1, cnt<=0.
  - Otherwise cnt holds at PACK (so no reads issue) until the slot frees; the transfer happens on the first edge it is free.
- Sustained throughput: PACK reads per PACK+1 cycles. The one-cycle bubble is accepted.
- Output handshake:
  - o_valid, o_data and o_keep stay stable while o_valid && !i_ready.
  - o_valid clears on accept unless a new word loads at the same edge; back-to-back words are permitted.
- Flush:
  - i_flush sets flush_pend; new reads stop at once.
  - State FILL->DRAIN at the next edge.
  - In DRAIN, wait until inflight==0 (an in-flight entry is still captured into the word) and the output slot is free.
  - Then, if 0<cnt<PACK: emit o_data with lanes >= cnt zeroed, o_keep = (1<<cnt)-1, cnt<=0.
  - If cnt==PACK: emit a full word. If cnt==0: emit nothing.
  - At the end of DRAIN: flush_pend<=0, state->FILL.
  - i_flush while already in DRAIN is ignored.
  - i_flush coincident with the capture completing a full word: the full word transfers normally and the flush then emits nothing.
- Empty boundary:
  - i_rempty is sampled only combinationally for o_rd; the FIFO's registered empty already reflects the previous read.
  - o_rd is never asserted while i_rempty=1.
- Width rules:
  - cnt is CW bits, range 0..PACK.
  - Lane select is cnt[CW-2:0]; no wrap occurs because cnt saturates at PACK.

Decomposition:
- Shared package/header: state encodings (FILL=1'b0, DRAIN=1'b1) and a keep-mask helper function ((1<<n)-1, PACK bits).
- No sub-module: accumulator, counters and the 2-state FSM stay in one module of about 150-250 lines.

Test Plan:
- Steady stream: FIFO preloaded with 0x01..0x08, i_ready=1 -> two words, 0x04030201 then 0x08070605, o_keep=4'hF; o_rd pattern 4 high, 1 low.
- Backpressure: preload 0x10..0x17, i_ready=0 for 10 cycles -> first word 0x13121110 held stable; o_rd stops after 4 more pops (cnt=PACK); on i_ready=1, 0x17161514 follows on the next accept.
- Partial flush: 3 entries 0xA1,0xA2,0xA3 then FIFO empty; pulse i_flush -> one word 0x00A3A2A1, o_keep=4'b0111; o_busy drops the cycle after the accept.
- Flush with read in flight: pulse i_flush the cycle o_rd pops the 2nd of 0xB1,0xB2,0xB3 -> word 0x0000B2B1, o_keep=4'b0011; 0xB3 remains in the FIFO and lands in lane 0 of the next word.
- Empty flush and corners: i_flush with cnt=0 -> no o_valid. Empty FIFO for 20 cycles -> o_rd never high.
- Async reset mid-word: assert i_rst_n=0 after 2 lanes captured -> all outputs 0 immediately. After release with 0xC1..0xC4 in the FIFO -> 0xC4C3C2C1, no stale lanes.
